// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared types and constants for the fetch PC sequencer
package pc_sequencer_pkg;

  localparam int INSN_ADDR_WIDTH = 32;
  localparam int FLUSH_CNT_WIDTH = 3;

  typedef logic [INSN_ADDR_WIDTH-1:0] InsnAddrPath;
  typedef logic [31:0]                BranchStatPath;

  localparam InsnAddrPath INSN_PC_INC = InsnAddrPath'(4);

  typedef enum logic [1:0] {
    SEQ_RUN     = 2'd0,
    SEQ_PENDING = 2'd1,
    SEQ_FLUSH   = 2'd2
  } SeqStatePath;

endpackage

// File: rtl/branch_stat_counter.sv
// rtl/branch_stat_counter.sv - pair of enable-driven wrapping branch statistics counters
module branch_stat_counter
  import pc_sequencer_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          br_inc,
  input  logic          taken_inc,
  output BranchStatPath br_count,
  output BranchStatPath taken_count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      br_count    <= '0;
      taken_count <= '0;
    end else begin
      if (br_inc)    br_count    <= br_count + BranchStatPath'(1);
      if (taken_inc) taken_count <= taken_count + BranchStatPath'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch PC sequencer with buffered redirect and wrong-path squash
// Optional branch statistics counters enabled by PC_SEQ_BRANCH_STATS_EN.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter InsnAddrPath RESET_VECTOR = '0,
  parameter int          FLUSH_DEPTH  = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          brValid,
  input  logic          brTaken,
  input  InsnAddrPath   brTarget,
  output InsnAddrPath   pcOut,
  output logic          squash,
  output logic          redirectPending,
  output BranchStatPath brCount,
  output BranchStatPath takenCount
);

  localparam logic [FLUSH_CNT_WIDTH-1:0] FLUSH_LOAD = FLUSH_CNT_WIDTH'(FLUSH_DEPTH);
  localparam logic [FLUSH_CNT_WIDTH-1:0] CNT_ONE    = FLUSH_CNT_WIDTH'(1);

  SeqStatePath                state, state_next;
  InsnAddrPath                pc, pc_next;
  InsnAddrPath                pend_target, pend_next;
  logic [FLUSH_CNT_WIDTH-1:0] flush_cnt, cnt_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= SEQ_RUN;
      pc          <= RESET_VECTOR;
      pend_target <= '0;
      flush_cnt   <= '0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      pend_target <= pend_next;
      flush_cnt   <= cnt_next;
    end
  end

  // Branches seen in PENDING (same branch held by EX) or FLUSH (wrong path) are ignored.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    pend_next  = pend_target;
    cnt_next   = flush_cnt;
    case (state)
      SEQ_RUN: begin
        if (!stall) begin
          if (brValid && brTaken) begin
            pc_next    = brTarget;
            cnt_next   = FLUSH_LOAD;
            state_next = SEQ_FLUSH;
          end else begin
            pc_next = pc + INSN_PC_INC;
          end
        end else if (brValid && brTaken) begin
          pend_next  = brTarget;
          state_next = SEQ_PENDING;
        end
      end
      SEQ_PENDING: begin
        if (!stall) begin
          pc_next    = pend_target;
          cnt_next   = FLUSH_LOAD;
          state_next = SEQ_FLUSH;
        end
      end
      SEQ_FLUSH: begin
        if (!stall) begin
          pc_next  = pc + INSN_PC_INC;
          cnt_next = flush_cnt - CNT_ONE;
          if (flush_cnt == CNT_ONE) state_next = SEQ_RUN;
        end
      end
      default: state_next = SEQ_RUN;
    endcase
  end

  assign pcOut           = pc;
  assign squash          = (state == SEQ_FLUSH);
  assign redirectPending = (state == SEQ_PENDING);

`ifdef PC_SEQ_BRANCH_STATS_EN
  logic br_inc, taken_inc;

  // A stalled not-taken branch is re-presented by EX, so it is counted once unstalled.
  assign br_inc    = (state == SEQ_RUN) && brValid && (!stall || brTaken);
  assign taken_inc = !stall && (((state == SEQ_RUN) && brValid && brTaken) ||
                                (state == SEQ_PENDING));

  branch_stat_counter u_stats (
    .clk         (clk),
    .rst         (rst),
    .br_inc      (br_inc),
    .taken_inc   (taken_inc),
    .br_count    (brCount),
    .taken_count (takenCount)
  );
`else
  assign brCount    = '0;
  assign takenCount = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

`ifdef PC_SEQ_BRANCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, stall, brValid, brTaken;
  InsnAddrPath   brTarget, pcOut;
  logic          squash, redirectPending;
  BranchStatPath brCount, takenCount;

  int vectors = 0;
  int miscompares = 0;

  pc_sequencer #(
    .RESET_VECTOR (32'h100),
    .FLUSH_DEPTH  (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .brValid         (brValid),
    .brTaken         (brTaken),
    .brTarget        (brTarget),
    .pcOut           (pcOut),
    .squash          (squash),
    .redirectPending (redirectPending),
    .brCount         (brCount),
    .takenCount      (takenCount)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [31:0] pc_exp,
                             input logic sq_exp, input logic pend_exp);
    check({tag, ".pc"}, pcOut, pc_exp);
    check({tag, ".squash"}, {31'd0, squash}, {31'd0, sq_exp});
    check({tag, ".pending"}, {31'd0, redirectPending}, {31'd0, pend_exp});
  endtask

  task automatic check_cnt(input string tag, input int br_n, input int taken_n);
    check({tag, ".brCount"}, brCount, STATS ? 32'(br_n) : 32'd0);
    check({tag, ".takenCount"}, takenCount, STATS ? 32'(taken_n) : 32'd0);
  endtask

  task automatic drive_br(input logic v, input logic t, input logic [31:0] tgt);
    brValid  = v;
    brTaken  = t;
    brTarget = tgt;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0;
    drive_br(1'b0, 1'b0, 32'h0);
    step(); step();
    check_state("reset", 32'h100, 1'b0, 1'b0);
    check_cnt("reset", 0, 0);

    rst = 1'b0;
    step(); check_state("seq1", 32'h104, 1'b0, 1'b0);
    step(); check_state("seq2", 32'h108, 1'b0, 1'b0);

    drive_br(1'b1, 1'b1, 32'h200);
    step(); check_state("redir", 32'h200, 1'b1, 1'b0);
    check_cnt("redir", 1, 1);
    drive_br(1'b0, 1'b0, 32'h0);
    step(); check_state("flush2", 32'h204, 1'b1, 1'b0);
    step(); check_state("flush_end", 32'h208, 1'b0, 1'b0);

    stall = 1'b1;
    drive_br(1'b1, 1'b1, 32'h300);
    step(); check_state("pend1", 32'h208, 1'b0, 1'b1);
    check_cnt("pend1", 2, 1);
    step(); check_state("pend2", 32'h208, 1'b0, 1'b1);
    step(); check_state("pend3", 32'h208, 1'b0, 1'b1);
    stall = 1'b0;
    drive_br(1'b0, 1'b0, 32'h0);
    step(); check_state("pend_apply", 32'h300, 1'b1, 1'b0);
    check_cnt("pend_apply", 2, 2);

    drive_br(1'b1, 1'b1, 32'h400);
    step(); check_state("sq_ign1", 32'h304, 1'b1, 1'b0);
    step(); check_state("sq_ign2", 32'h308, 1'b0, 1'b0);
    check_cnt("sq_ign", 2, 2);

    drive_br(1'b1, 1'b0, 32'h0);
    step(); check_state("not_taken", 32'h30C, 1'b0, 1'b0);
    check_cnt("not_taken", 3, 2);

    stall = 1'b1;
    step(); check_state("stall_nt", 32'h30C, 1'b0, 1'b0);
    check_cnt("stall_nt", 3, 2);
    stall = 1'b0;

    drive_br(1'b1, 1'b1, 32'h500);
    step(); check_state("redir2", 32'h500, 1'b1, 1'b0);
    check_cnt("redir2", 4, 3);
    rst = 1'b1;
    drive_br(1'b0, 1'b0, 32'h0);
    step(); check_state("rst_flush", 32'h100, 1'b0, 1'b0);
    check_cnt("rst_flush", 0, 0);
    rst = 1'b0;
    step(); check_state("post_rst", 32'h104, 1'b0, 1'b0);

    stall = 1'b1;
    drive_br(1'b1, 1'b1, 32'h600);
    step(); check_state("pend_b", 32'h104, 1'b0, 1'b1);
    rst = 1'b1;
    step(); check_state("rst_pend", 32'h100, 1'b0, 1'b0);
    check_cnt("rst_pend", 0, 0);
    rst = 1'b0; stall = 1'b0;
    drive_br(1'b0, 1'b0, 32'h0);
    step(); check_state("discard", 32'h104, 1'b0, 1'b0);

    drive_br(1'b1, 1'b1, 32'h700);
    step(); check_state("redir3", 32'h700, 1'b1, 1'b0);
    drive_br(1'b0, 1'b0, 32'h0);
    stall = 1'b1;
    step(); check_state("flush_stall", 32'h700, 1'b1, 1'b0);
    stall = 1'b0;
    step(); check_state("flush_res1", 32'h704, 1'b1, 1'b0);
    step(); check_state("flush_res2", 32'h708, 1'b0, 1'b0);
    check_cnt("final", 1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-side controller that owns the program counter and sequences it from branch resolutions produced by BranchUnit in EX. Advances the PC every unstalled cycle, applies taken redirects, buffers a redirect that arrives while the front end is stalled, and squashes the wrong-path slots already in flight. Sits between the EX-stage branch logic and the instruction-fetch address port of the pipelined core.

## Interface
Parameters:
- RESET_VECTOR, 0: PC value loaded on reset (InsnAddrPath).
- FLUSH_DEPTH, 2: wrong-path slots between IF and EX to squash after a redirect; legal range 1..7.

Ports:
- clk  in  1  clock; one clock domain, all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- stall  in  1  freeze PC, state and flush counter this cycle.
- brValid  in  1  EX holds a resolved branch this cycle.
- brTaken  in  1  resolved branch is taken (qualified by brValid).
- brTarget  in  INSN_ADDR_WIDTH  redirect target, used unmodified.
- pcOut  out  INSN_ADDR_WIDTH  current fetch address (registered).
- squash  out  1  EX slot is wrong-path; suppress its writeback/stores.
- redirectPending  out  1  a taken redirect is buffered behind a stall.
- brCount  out  32  resolved branches accepted (see Configuration).
- takenCount  out  32  taken redirects applied (see Configuration).

## Operation
- States: SEQ_RUN, SEQ_PENDING, SEQ_FLUSH. Registers: pc, pendTarget, flushCnt, state.
- Reset (any state, any cycle, dominates all inputs): pc=RESET_VECTOR, state=SEQ_RUN, flushCnt=0, pendTarget=0, squash=0, redirectPending=0, counters=0; buffered redirect discarded.
- SEQ_RUN, stall=0: brValid&brTaken -> pc<=brTarget, flushCnt<=FLUSH_DEPTH, -> SEQ_FLUSH; otherwise pc<=pc+INSN_PC_INC (mod 2^INSN_ADDR_WIDTH, wraps silently).
- SEQ_RUN, stall=1: pc holds; brValid&brTaken -> pendTarget<=brTarget, -> SEQ_PENDING; not-taken branch causes no state change.
- SEQ_PENDING: brValid ignored (EX holds same branch). On first cycle with stall=0: pc<=pendTarget, flushCnt<=FLUSH_DEPTH, -> SEQ_FLUSH.
- SEQ_FLUSH: squash=1. stall=0: pc<=pc+INSN_PC_INC, flushCnt decrements; flushCnt==1 -> SEQ_RUN. stall=1: pc and flushCnt hold, squash stays 1. brValid ignored (wrong-path branch).
- squash = (state==SEQ_FLUSH); redirectPending = (state==SEQ_PENDING); both decoded from registered state, no input-to-output comb path.

## Timing
- Redirect latency: taken branch accepted at cycle N (SEQ_RUN, no stall) -> pcOut=brTarget at N+1; squash high N+1..N+FLUSH_DEPTH (unstalled); SEQ_RUN at N+FLUSH_DEPTH+1.
- Buffered redirect: taken at N with stall; stall falls at M -> pcOut=target at M+1; squash M+1..M+FLUSH_DEPTH.
- Branch accepted during the last squash cycle: ignored (it is wrong-path).
- Sequential PC: pcOut increments by INSN_PC_INC each unstalled cycle; first fetch at RESET_VECTOR in cycle after rst deasserts.

## Configuration
- PC_SEQ_BRANCH_STATS_EN defined: brCount increments on every accepted brValid (SEQ_RUN, including stalled-taken capture, excluding ignored ones); takenCount increments when a redirect is applied to pc. Both 32-bit, wrap, reset to 0.
- Undefined: counter logic absent; brCount and takenCount tied to 0; ports remain.

## Structure
- Shared package: SeqStatePath enum (SEQ_RUN, SEQ_PENDING, SEQ_FLUSH), FLUSH_CNT_WIDTH=3, BranchStatPath (32-bit); reuse InsnAddrPath, INSN_PC_INC, INSN_ADDR_WIDTH.
- One sub-module: branch_stat_counter (two enable-driven 32-bit counters), instantiated only under PC_SEQ_BRANCH_STATS_EN.

## Test plan
- Reset with RESET_VECTOR=0x100, INSN_PC_INC=4, no branches 4 cycles -> pcOut 0x100,0x104,0x108,0x10C; squash=0.
- Taken branch brTarget=0x200 at pcOut=0x108 -> pcOut 0x200, 0x204, 0x208; squash high exactly 2 cycles; takenCount=1.
- Stall high 3 cycles with taken brTarget=0x300 in first stalled cycle -> pcOut frozen, redirectPending=1 for 3 cycles; cycle after stall drops pcOut=0x300, then 2 squash cycles.
- brValid&brTaken=0x400 during squash -> ignored; pcOut continues sequentially; brCount unchanged.
- Not-taken branch (brTaken=0) -> pcOut+4, no squash; brCount+1, takenCount unchanged.
- rst asserted mid-SEQ_FLUSH and mid-SEQ_PENDING -> next cycle pcOut=0x100, squash=0, redirectPending=0, counters 0.
